// File: rtl/mi3_botao_pkg.sv
// Shared register map and bus types for the mi3 push-button input slave.
package mi3_botao_pkg;

  typedef logic [1:0] addr_t;

  localparam addr_t REG_DATA    = 2'd0;
  localparam addr_t REG_RSVD    = 2'd1;
  localparam addr_t REG_IRQMASK = 2'd2;
  localparam addr_t REG_EDGE    = 2'd3;

  // Avalon write strobe is active-low and only counts while selected.
  function automatic logic bus_write(input logic cs, input logic wr_n);
    return cs & ~wr_n;
  endfunction

endpackage

// File: rtl/mi3_debounce_bit.sv
// One button lane: 2-flop synchronizer, stability counter, debounced flop,
// and a one-cycle pulse whenever the debounced value has just changed.
module mi3_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic stable_o,
  output logic chg_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Released (1) is the safe reset value for active-low buttons.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable_o = stable_q;
  assign chg_o    = stable_q ^ prev_q;

endmodule

// File: rtl/mi3_botao_in.sv
// Avalon-MM push-button input slave: debounced data, edge capture, masked irq.
// Define MI3_BOTAO_IN_BOTH_EDGES_EN to capture releases as well as presses.
module mi3_botao_in
  import mi3_botao_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  addr_t            address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable, chg, edge_set;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             irq_q, irq_d;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mi3_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (clk),
      .rst_i   (reset),
      .pin_i   (in_port[i]),
      .stable_o(stable[i]),
      .chg_o   (chg[i])
    );
  end

  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

`ifdef MI3_BOTAO_IN_BOTH_EDGES_EN
  assign edge_set = chg;
`else
  // Pressed is 0, so a change that lands on 0 is a press.
  assign edge_set = chg & ~stable;
`endif

  assign wr = bus_write(chipselect, write_n);

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr && address == REG_IRQMASK) mask_d = writedata[WIDTH-1:0];
    if (wr && address == REG_EDGE)    edge_d = edge_q & ~writedata[WIDTH-1:0];
    // A new edge beats a simultaneous clear.
    edge_d = edge_d | edge_set;
    irq_d  = |(edge_q & mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      edge_q <= edge_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      REG_DATA:    readdata = 32'(stable);
      REG_IRQMASK: readdata = 32'(mask_q);
      REG_EDGE:    readdata = 32'(edge_q);
      default:     readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
